// File: rtl/boolean_assignment_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boolean_assignment_commit_pkg
// Purpose  : Shared widths and FSM state encoding for the assignment commit stage.
// Revision : 1.0 - initial release
// ============================================================================
package boolean_assignment_commit_pkg;

    localparam int NUMBER_OF_BOOLEAN_VARIABLES = 2;
    localparam int COST_WIDTH                  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECIDE = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/boolean_assignment_commit_accept.sv
`default_nettype none
// ============================================================================
// Module   : boolean_accept_decision
// Purpose  : Metropolis-style accept test: take improvements, or worse moves by chance.
// Revision : 1.0 - initial release
// ============================================================================
module boolean_accept_decision #(
    parameter int         COST_WIDTH       = boolean_assignment_commit_pkg::COST_WIDTH,
    parameter logic [7:0] ACCEPT_THRESHOLD = 8'd32
) (
    input  logic [COST_WIDTH-1:0] i_new_cost,
    input  logic [COST_WIDTH-1:0] i_current_cost,
    input  logic [7:0]            i_random,
    output logic                  o_accept
);

    // Both comparisons are unsigned; a random byte equal to the threshold rejects.
    assign o_accept = (i_new_cost <= i_current_cost) | (i_random < ACCEPT_THRESHOLD);

endmodule
`default_nettype wire

// File: rtl/boolean_assignment_commit.sv
`default_nettype none
// ============================================================================
// Module   : boolean_assignment_commit
// Purpose  : Captures proposals, decides accept/reject and commits the assignment.
// Revision : 1.0 - initial release
// ============================================================================
module boolean_assignment_commit #(
    parameter int          NUM_VARS         = boolean_assignment_commit_pkg::NUMBER_OF_BOOLEAN_VARIABLES,
    parameter int          COST_WIDTH       = boolean_assignment_commit_pkg::COST_WIDTH,
    parameter logic [7:0]  ACCEPT_THRESHOLD = 8'd32,
    parameter logic [15:0] MAX_ITERATIONS   = 16'd1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_start,
    input  logic [NUM_VARS-1:0]   in_initial_assignment_boolean,
    input  logic [COST_WIDTH-1:0] in_initial_cost,
    input  logic                  in_proposal_valid,
    output logic                  out_proposal_ready,
    input  logic [NUM_VARS-1:0]   in_new_assignment_boolean,
    input  logic [COST_WIDTH-1:0] in_new_cost,
    input  logic [7:0]            in_random,
    output logic [NUM_VARS-1:0]   out_current_assignment_boolean,
    output logic                  out_last_accepted,
    output logic [15:0]           out_iteration_count,
    output logic                  out_done,
    output logic                  out_solved
);

    import boolean_assignment_commit_pkg::*;

    state_e                r_state_q,      w_state_d;
    logic [NUM_VARS-1:0]   r_assign_q,     w_assign_d;
    logic [COST_WIDTH-1:0] r_cost_q,       w_cost_d;
    logic [NUM_VARS-1:0]   r_new_assign_q, w_new_assign_d;
    logic [COST_WIDTH-1:0] r_new_cost_q,   w_new_cost_d;
    logic [7:0]            r_random_q,     w_random_d;
    logic                  r_accept_q,     w_accept_d;
    logic                  r_last_q,       w_last_d;
    logic [15:0]           r_count_q,      w_count_d;
    logic                  r_done_q,       w_done_d;
    logic                  r_solved_q,     w_solved_d;
    logic                  r_ready_q,      w_ready_d;

    logic                  w_accept;
    logic [COST_WIDTH-1:0] w_commit_cost;
    logic [15:0]           w_count_inc;

    boolean_accept_decision #(
        .COST_WIDTH       (COST_WIDTH),
        .ACCEPT_THRESHOLD (ACCEPT_THRESHOLD)
    ) u_accept (
        .i_new_cost     (r_new_cost_q),
        .i_current_cost (r_cost_q),
        .i_random       (r_random_q),
        .o_accept       (w_accept)
    );

    assign w_commit_cost = r_accept_q ? r_new_cost_q : r_cost_q;
    assign w_count_inc   = r_count_q + 16'd1;

    always_comb begin
        w_state_d      = r_state_q;
        w_assign_d     = r_assign_q;
        w_cost_d       = r_cost_q;
        w_new_assign_d = r_new_assign_q;
        w_new_cost_d   = r_new_cost_q;
        w_random_d     = r_random_q;
        w_accept_d     = r_accept_q;
        w_last_d       = r_last_q;
        w_count_d      = r_count_q;
        w_done_d       = r_done_q;
        w_solved_d     = r_solved_q;
        w_ready_d      = r_ready_q;

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (in_start) begin
                    w_assign_d = in_initial_assignment_boolean;
                    w_cost_d   = in_initial_cost;
                    w_count_d  = 16'd0;
                    w_last_d   = 1'b0;
                    // An already-satisfying start finishes without consuming a proposal.
                    if (in_initial_cost == '0) begin
                        w_state_d  = ST_DONE;
                        w_done_d   = 1'b1;
                        w_solved_d = 1'b1;
                        w_ready_d  = 1'b0;
                    end else begin
                        w_state_d  = ST_WAIT;
                        w_done_d   = 1'b0;
                        w_solved_d = 1'b0;
                        w_ready_d  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (in_proposal_valid) begin
                    w_new_assign_d = in_new_assignment_boolean;
                    w_new_cost_d   = in_new_cost;
                    w_random_d     = in_random;
                    w_ready_d      = 1'b0;
                    w_state_d      = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_accept_d = w_accept;
                w_state_d  = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (r_accept_q) begin
                    w_assign_d = r_new_assign_q;
                    w_cost_d   = r_new_cost_q;
                end
                w_last_d  = r_accept_q;
                w_count_d = w_count_inc;
                // A solved assignment wins over an exhausted budget.
                if (w_commit_cost == '0) begin
                    w_state_d  = ST_DONE;
                    w_done_d   = 1'b1;
                    w_solved_d = 1'b1;
                end else if (w_count_inc == MAX_ITERATIONS) begin
                    w_state_d  = ST_DONE;
                    w_done_d   = 1'b1;
                    w_solved_d = 1'b0;
                end else begin
                    w_state_d  = ST_WAIT;
                    w_ready_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_ready_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_assign_q     <= '0;
            r_cost_q       <= '0;
            r_new_assign_q <= '0;
            r_new_cost_q   <= '0;
            r_random_q     <= '0;
            r_accept_q     <= 1'b0;
            r_last_q       <= 1'b0;
            r_count_q      <= '0;
            r_done_q       <= 1'b0;
            r_solved_q     <= 1'b0;
            r_ready_q      <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_assign_q     <= w_assign_d;
            r_cost_q       <= w_cost_d;
            r_new_assign_q <= w_new_assign_d;
            r_new_cost_q   <= w_new_cost_d;
            r_random_q     <= w_random_d;
            r_accept_q     <= w_accept_d;
            r_last_q       <= w_last_d;
            r_count_q      <= w_count_d;
            r_done_q       <= w_done_d;
            r_solved_q     <= w_solved_d;
            r_ready_q      <= w_ready_d;
        end
    end

    assign out_proposal_ready             = r_ready_q;
    assign out_current_assignment_boolean = r_assign_q;
    assign out_last_accepted              = r_last_q;
    assign out_iteration_count            = r_count_q;
    assign out_done                       = r_done_q;
    assign out_solved                     = r_solved_q;

endmodule
`default_nettype wire

// File: tb/tb_boolean_assignment_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_boolean_assignment_commit
// Purpose  : Scoreboard bench: directed scenarios plus randomized runs vs a run model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boolean_assignment_commit;

    localparam int          NV   = 2;
    localparam int          CW   = 8;
    localparam logic [7:0]  THR  = 8'd32;
    localparam logic [15:0] MAXI = 16'd4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_start = 1'b0;
    logic [NV-1:0] in_initial_assignment_boolean = '0;
    logic [CW-1:0] in_initial_cost = '0;
    logic          in_proposal_valid = 1'b0;
    logic          out_proposal_ready;
    logic [NV-1:0] in_new_assignment_boolean = '0;
    logic [CW-1:0] in_new_cost = '0;
    logic [7:0]    in_random = '0;
    logic [NV-1:0] out_current_assignment_boolean;
    logic          out_last_accepted;
    logic [15:0]   out_iteration_count;
    logic          out_done;
    logic          out_solved;

    boolean_assignment_commit #(
        .NUM_VARS         (NV),
        .COST_WIDTH       (CW),
        .ACCEPT_THRESHOLD (THR),
        .MAX_ITERATIONS   (MAXI)
    ) dut (
        .clk                            (clk),
        .reset                          (reset),
        .in_start                       (in_start),
        .in_initial_assignment_boolean  (in_initial_assignment_boolean),
        .in_initial_cost                (in_initial_cost),
        .in_proposal_valid              (in_proposal_valid),
        .out_proposal_ready             (out_proposal_ready),
        .in_new_assignment_boolean      (in_new_assignment_boolean),
        .in_new_cost                    (in_new_cost),
        .in_random                      (in_random),
        .out_current_assignment_boolean (out_current_assignment_boolean),
        .out_last_accepted              (out_last_accepted),
        .out_iteration_count            (out_iteration_count),
        .out_done                       (out_done),
        .out_solved                     (out_solved)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0] asg;
        logic          last;
        logic [15:0]   count;
        logic          done;
        logic          solved;
        logic          ready;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Run-level model: the committed assignment and cost of one annealing run.
    logic [NV-1:0] m_asg = '0;
    logic [CW-1:0] m_cost = '0;
    logic [15:0]   m_count = '0;
    logic          m_last = 1'b0;
    logic          m_done = 1'b0;
    logic          m_solved = 1'b0;
    logic          m_run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".assign"}, 32'(out_current_assignment_boolean), 32'(m_asg));
        check({tag, ".last"},   32'(out_last_accepted),              32'(m_last));
        check({tag, ".count"},  32'(out_iteration_count),            32'(m_count));
        check({tag, ".done"},   32'(out_done),                       32'(m_done));
        check({tag, ".solved"}, 32'(out_solved),                     32'(m_solved));
        check({tag, ".ready"},  32'(out_proposal_ready),             32'(m_run));
    endtask

    task automatic settle();
        int k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d pending, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_asg = '0; m_cost = '0; m_count = '0; m_last = 1'b0;
        m_done = 1'b0; m_solved = 1'b0; m_run = 1'b0;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start(input logic [NV-1:0] a, input logic [CW-1:0] c, input string tag);
        settle();
        in_start = 1'b1;
        in_initial_assignment_boolean = a;
        in_initial_cost = c;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        if (!m_run) begin
            m_asg = a; m_cost = c; m_count = '0; m_last = 1'b0;
            m_done = (c == '0); m_solved = (c == '0); m_run = (c != '0);
        end
        check_outputs(tag);
    endtask

    task automatic propose(input logic [NV-1:0] a, input logic [CW-1:0] c, input logic [7:0] r);
        int   k = 0;
        logic acc;
        exp_t e;
        @(negedge clk);
        in_proposal_valid = 1'b1;
        in_new_assignment_boolean = a;
        in_new_cost = c;
        in_random = r;
        while (!out_proposal_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!out_proposal_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: ready=0, expected 1 within 10 cycles");
            in_proposal_valid = 1'b0;
            return;
        end
        acc = (c <= m_cost) || (r < THR);
        if (acc) begin
            m_asg = a;
            m_cost = c;
        end
        m_last = acc;
        m_count = m_count + 16'd1;
        if (m_cost == '0) begin
            m_done = 1'b1; m_solved = 1'b1; m_run = 1'b0;
        end else if (m_count == MAXI) begin
            m_done = 1'b1; m_solved = 1'b0; m_run = 1'b0;
        end
        e.asg = m_asg; e.last = m_last; e.count = m_count;
        e.done = m_done; e.solved = m_solved; e.ready = m_run;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_proposal_valid = 1'b0;
        in_new_assignment_boolean = NV'($urandom());
        in_new_cost = CW'($urandom());
        in_random = 8'($urandom());
    endtask

    // Valid asserted while the block is not in WAIT must change nothing.
    task automatic ignored_valid(input string tag);
        settle();
        in_proposal_valid = 1'b1;
        in_new_assignment_boolean = ~m_asg;
        in_new_cost = '0;
        in_random = 8'd0;
        repeat (4) @(negedge clk);
        in_proposal_valid = 1'b0;
        check_outputs(tag);
    endtask

    // Monitor: on each handshake, wait for the commit and compare against the scoreboard.
    initial begin
        exp_t e;
        logic rst_seen;
        forever begin
            @(posedge clk);
            if (!reset && in_proposal_valid && out_proposal_ready) begin
                rst_seen = 1'b0;
                @(posedge clk);
                if (reset) rst_seen = 1'b1;
                #1;
                if (!rst_seen) check("mon.ready_in_decide", 32'(out_proposal_ready), 32'd0);
                @(posedge clk);
                if (reset) rst_seen = 1'b1;
                #1;
                if (!rst_seen) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL mon.unexpected_commit: got a handshake, expected none");
                    end else begin
                        e = sb_q.pop_front();
                        check("mon.assign", 32'(out_current_assignment_boolean), 32'(e.asg));
                        check("mon.last",   32'(out_last_accepted),              32'(e.last));
                        check("mon.count",  32'(out_iteration_count),            32'(e.count));
                        check("mon.done",   32'(out_done),                       32'(e.done));
                        check("mon.solved", 32'(out_solved),                     32'(e.solved));
                        check("mon.ready",  32'(out_proposal_ready),             32'(e.ready));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] r;
        repeat (2) @(negedge clk);
        do_reset();

        // Accept an improvement, then reject/accept around the threshold.
        start(2'b00, 8'd3, "start1");
        propose(2'b01, 8'd1, 8'd200);
        propose(2'b10, 8'd2, 8'd200);
        propose(2'b10, 8'd2, 8'd10);
        settle();
        check_outputs("after_accept_random");
        start(2'b11, 8'd1, "start_in_wait_ignored");
        propose(2'b11, 8'd3, 8'd32);
        settle();
        check_outputs("threshold_rejects_budget_end");

        // Cost-0 proposal solves the run; later valids are ignored.
        start(2'b11, 8'd6, "start2");
        propose(2'b00, 8'd0, 8'd100);
        ignored_valid("solved_hold");

        // Budget exhaustion with only worse proposals.
        start(2'b10, 8'd5, "start3");
        repeat (4) propose(2'b01, 8'd9, 8'd255);
        ignored_valid("budget_hold");

        // Reset while a proposal sits in DECIDE discards it.
        start(2'b01, 8'd7, "start4");
        @(negedge clk);
        in_proposal_valid = 1'b1;
        in_new_assignment_boolean = 2'b11;
        in_new_cost = 8'd2;
        @(posedge clk);
        #1;
        in_proposal_valid = 1'b0;
        do_reset();
        start(2'b10, 8'd0, "start_cost0");

        // Reset outranks a simultaneous start.
        @(negedge clk);
        reset = 1'b1;
        in_start = 1'b1;
        in_initial_assignment_boolean = 2'b11;
        in_initial_cost = 8'd5;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        m_asg = '0; m_cost = '0; m_count = '0; m_last = 1'b0;
        m_done = 1'b0; m_solved = 1'b0; m_run = 1'b0;
        check_outputs("reset_beats_start");
        @(negedge clk);
        reset = 1'b0;

        // Randomized runs.
        for (int run = 0; run < 40; run++) begin
            start(NV'($urandom()), ($urandom_range(0, 7) == 0) ? 8'd0 : CW'($urandom_range(1, 15)), "rand_start");
            while (m_run) begin
                case ($urandom_range(0, 3))
                    0:       r = THR - 8'd1;
                    1:       r = THR;
                    default: r = 8'($urandom());
                endcase
                propose(NV'($urandom()), CW'($urandom_range(0, 15)), r);
                if (m_run && $urandom_range(0, 5) == 0)
                    start(NV'($urandom()), CW'($urandom_range(0, 15)), "rand_start_ignored");
            end
            if ($urandom_range(0, 2) == 0)
                ignored_valid("rand_done_hold");
        end

        settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
